id_ex_pipeline_register: RTL

ID/EX pipeline register and hazard-stall controller, directly upstream of the forwarding unit.
- Captures the decoded instruction from ID each cycle and presents it to EX.
- Presents `ex_rD_address`, `ex_storing` and operand data to the forwarding logic.
- Inserts bubbles on load-use hazards.
- Holds EX for multi-cycle ALU ops.
- Honours branch flush and memory stall.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 37 +++
 rtl/id_ex_pipeline_register.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline widths, EX-stage state encoding and bubble.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 6;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [0:REG_ADDR_W-1] rdAddress;
        logic                  regWrite;
        logic                  load;
        logic                  storing;
        logic [0:ALU_OP_W-1]   aluOp;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Load-use detection and ID stall request for the front end.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import cpu_pkg::*;
(
    input  logic                  i_rstN,
    input  logic                  i_exValid,
    input  logic                  i_exLoad,
    input  logic [0:REG_ADDR_W-1] i_exRdAddress,
    input  logic                  i_idValid,
    input  logic [0:REG_ADDR_W-1] i_idRaAddress,
    input  logic [0:REG_ADDR_W-1] i_idRbAddress,
    input  logic                  i_flush,
    input  logic                  i_memStall,
    input  logic                  i_mcBusy,
    output logic                  o_loadUse,
    output logic                  o_stallId
);

    logic w_srcMatch;

    assign w_srcMatch = (i_idRaAddress == i_exRdAddress) |
                        (i_idRbAddress == i_exRdAddress);

    // r0 is never a real dependency, so a load to r0 cannot create a hazard
    assign o_loadUse = i_exValid & i_exLoad & (i_exRdAddress != '0) &
                       i_idValid & w_srcMatch;

    assign o_stallId = i_rstN &
                       (i_memStall | (~i_mcBusy & o_loadUse & ~i_flush) | i_mcBusy);

endmodule
`default_nettype wire

// File: rtl/id_ex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_register
// Description : ID/EX register with load-use bubbles, multi-cycle hold, flush.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_register
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MC_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [0:REG_ADDR_W-1] id_rA_address,
    input  logic [0:REG_ADDR_W-1] id_rB_address,
    input  logic [0:REG_ADDR_W-1] id_rD_address,
    input  logic                  id_reg_write,
    input  logic                  id_load,
    input  logic                  id_storing,
    input  logic                  id_multicycle,
    input  logic [0:ALU_OP_W-1]   id_alu_op,
    input  logic [0:DATA_WIDTH-1] id_rA_data,
    input  logic [0:DATA_WIDTH-1] id_rB_data,
    input  logic                  flush,
    input  logic                  mem_stall,
    output logic                  ex_valid,
    output logic [0:REG_ADDR_W-1] ex_rD_address,
    output logic                  ex_reg_write,
    output logic                  ex_load,
    output logic                  ex_storing,
    output logic [0:ALU_OP_W-1]   ex_alu_op,
    output logic [0:DATA_WIDTH-1] ex_rA_data,
    output logic [0:DATA_WIDTH-1] ex_rB_data,
    output logic                  ex_busy,
    output logic                  stall_id
);

    // Counter counts remaining busy edges; leaving on the edge after it hits 0
    // gives MC_LATENCY cycles of EX occupancy.
    localparam logic [0:3] c_MC_LOAD = 4'(MC_LATENCY - 1);

    state_t                r_state;
    logic [0:3]            r_mcCnt;
    logic                  r_flushPending;
    ctrl_t                 r_ctrl;
    logic [0:DATA_WIDTH-1] r_rAData;
    logic [0:DATA_WIDTH-1] r_rBData;

    logic  w_loadUse;
    logic  w_mcBusy;
    logic  w_capture;
    logic  w_takeId;
    logic  w_enterMc;
    ctrl_t w_idCtrl;

    assign w_mcBusy = (r_state == MC_BUSY);

    hazard_detect u_hazardDetect (
        .i_rstN        (rst_n),
        .i_exValid     (r_ctrl.valid),
        .i_exLoad      (r_ctrl.load),
        .i_exRdAddress (r_ctrl.rdAddress),
        .i_idValid     (id_valid),
        .i_idRaAddress (id_rA_address),
        .i_idRbAddress (id_rB_address),
        .i_flush       (flush),
        .i_memStall    (mem_stall),
        .i_mcBusy      (w_mcBusy),
        .o_loadUse     (w_loadUse),
        .o_stallId     (stall_id)
    );

    always_comb begin
        w_capture          = ~mem_stall & (~w_mcBusy | (r_mcCnt == '0));
        w_takeId           = id_valid & ~flush & ~r_flushPending & ~w_loadUse;
        w_enterMc          = w_takeId & id_multicycle;
        w_idCtrl           = BUBBLE;
        w_idCtrl.valid     = 1'b1;
        w_idCtrl.rdAddress = id_rD_address;
        w_idCtrl.regWrite  = id_reg_write;
        w_idCtrl.load      = id_load;
        w_idCtrl.storing   = id_storing;
        w_idCtrl.aluOp     = id_alu_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_mcCnt        <= '0;
            r_flushPending <= 1'b0;
            r_ctrl         <= BUBBLE;
            r_rAData       <= '0;
            r_rBData       <= '0;
        end else if (w_capture) begin
            r_flushPending <= 1'b0;
            if (w_takeId) begin
                r_ctrl   <= w_idCtrl;
                r_rAData <= id_rA_data;
                r_rBData <= id_rB_data;
            end else begin
                r_ctrl   <= BUBBLE;
                r_rAData <= '0;
                r_rBData <= '0;
            end
            if (w_enterMc) begin
                r_state <= MC_BUSY;
                r_mcCnt <= c_MC_LOAD;
            end else begin
                r_state <= RUN;
                r_mcCnt <= '0;
            end
        end else if (w_mcBusy) begin
            // A flush seen mid-op targets the instruction waiting in ID
            if (flush) begin
                r_flushPending <= 1'b1;
            end
            if (!mem_stall) begin
                r_mcCnt <= r_mcCnt - 4'd1;
            end
        end
    end

    assign ex_valid      = r_ctrl.valid;
    assign ex_rD_address = r_ctrl.rdAddress;
    assign ex_reg_write  = r_ctrl.regWrite;
    assign ex_load       = r_ctrl.load;
    assign ex_storing    = r_ctrl.storing;
    assign ex_alu_op     = r_ctrl.aluOp;
    assign ex_rA_data    = r_rAData;
    assign ex_rB_data    = r_rBData;
    assign ex_busy       = w_mcBusy;

endmodule
`default_nettype wire
